// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: scalar pass-through plus a 16-word serialiser for vector load/store.
// Optional base-alignment trap enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
   parameter int VROWS     = 4,
   parameter int ROW_WORDS = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           s_req_i,
   input  logic                           s_wr_i,
   input  logic [31:0]                    s_addr_i,
   input  logic [31:0]                    s_wdata_i,
   input  logic [1:0]                     s_byte_en_i,
   output logic                           s_gnt_o,
   output logic [31:0]                    s_rdata_o,
   input  logic                           v_req_i,
   input  logic                           v_wr_i,
   input  logic [31:0]                    v_base_addr_i,
   input  logic [VROWS*ROW_WORDS*32-1:0]  v_wdata_i,
   output logic [VROWS*ROW_WORDS*32-1:0]  v_rdata_o,
   output logic                           v_done_o,
   output logic                           v_err_o,
   output logic                           stall_o,
   output logic                           mem_req_o,
   output logic                           mem_wr_o,
   output logic [31:0]                    mem_addr_o,
   output logic [31:0]                    mem_wdata_o,
   output logic [1:0]                     mem_byte_en_o,
   input  logic [31:0]                    mem_rdata_i
);

   localparam int NWORDS = VROWS * ROW_WORDS;
   localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int VW     = NWORDS * 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      V_ACCESS = 2'd1,
      DONE     = 2'd2
   } state_t;

   state_t          state_r;
   logic [KW-1:0]   k_r;
   logic [31:0]     base_r;
   logic            wr_r;
   logic [VW-1:0]   v_rdata_r;
   logic            misalign_s;
   logic            last_word_s;
   logic [KW+4:0]   bit_off_s;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   assign misalign_s = (v_base_addr_i[3:0] != 4'd0);
`else
   assign misalign_s = 1'b0;
`endif

   assign last_word_s = (k_r == KW'(NWORDS - 1));
   assign bit_off_s   = {k_r, 5'd0};
   assign v_rdata_o   = v_rdata_r;
   assign v_err_o     = (state_r == IDLE) && v_req_i && misalign_s;

   // Sequencer state, word counter, latched vector parameters and load capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         k_r       <= '0;
         base_r    <= 32'd0;
         wr_r      <= 1'b0;
         v_rdata_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (v_req_i) begin
                  // Low nibble is dropped: rows are always 16-byte aligned in memory.
                  base_r  <= {v_base_addr_i[31:4], 4'd0};
                  wr_r    <= v_wr_i;
                  k_r     <= '0;
                  state_r <= misalign_s ? DONE : V_ACCESS;
               end else begin
                  state_r <= IDLE;
               end
            end
            V_ACCESS: begin
               if (!wr_r) begin
                  v_rdata_r[bit_off_s +: 32] <= mem_rdata_i;
               end else begin
                  v_rdata_r <= v_rdata_r;
               end
               if (last_word_s) begin
                  k_r     <= '0;
                  state_r <= DONE;
               end else begin
                  k_r     <= k_r + KW'(1);
                  state_r <= V_ACCESS;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               k_r     <= '0;
            end
         endcase
      end
   end

   // Memory port mux and core handshake; scalar path is combinational so idle scalar accesses add no latency.
   always_comb begin
      s_gnt_o       = 1'b0;
      s_rdata_o     = 32'd0;
      stall_o       = 1'b0;
      v_done_o      = 1'b0;
      mem_req_o     = 1'b0;
      mem_wr_o      = 1'b0;
      mem_addr_o    = 32'd0;
      mem_wdata_o   = 32'd0;
      mem_byte_en_o = 2'b00;
      case (state_r)
         IDLE: begin
            if (v_req_i) begin
               stall_o = 1'b1;
            end else begin
               s_gnt_o   = s_req_i;
               s_rdata_o = mem_rdata_i;
               mem_req_o = s_req_i;
               if (s_req_i) begin
                  mem_wr_o      = s_wr_i;
                  mem_addr_o    = s_addr_i;
                  mem_wdata_o   = s_wdata_i;
                  mem_byte_en_o = s_byte_en_i;
               end else begin
                  mem_wr_o = 1'b0;
               end
            end
         end
         V_ACCESS: begin
            stall_o       = 1'b1;
            mem_req_o     = 1'b1;
            mem_wr_o      = wr_r;
            mem_addr_o    = base_r + {{(30-KW){1'b0}}, k_r, 2'b00};
            mem_byte_en_o = 2'b11;
            if (wr_r) begin
               mem_wdata_o = v_wdata_i[bit_off_s +: 32];
            end else begin
               mem_wdata_o = 32'd0;
            end
         end
         DONE: begin
            v_done_o = 1'b1;
         end
         default: begin
            stall_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: scalar vector table, directed vector sequences,
// randomized traffic against a word-level memory reference model.
module tb_dmem_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic          s_req, s_wr;
   logic [31:0]   s_addr, s_wdata;
   logic [1:0]    s_be;
   logic          s_gnt;
   logic [31:0]   s_rdata;
   logic          v_req, v_wr;
   logic [31:0]   v_base;
   logic [511:0]  v_wdata, v_rdata;
   logic          v_done, v_err, stall;
   logic          mem_req, mem_wr;
   logic [31:0]   mem_addr, mem_wdata;
   logic [1:0]    mem_be;
   logic [31:0]   mem_rdata;

   logic [31:0]   mem [0:255];
   logic [31:0]   ref_mem [0:255];
   logic          mem_init;
   logic [511:0]  rd_shadow;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.VROWS(4), .ROW_WORDS(4)) dut (
      .clk(clk), .reset(reset),
      .s_req_i(s_req), .s_wr_i(s_wr), .s_addr_i(s_addr), .s_wdata_i(s_wdata),
      .s_byte_en_i(s_be), .s_gnt_o(s_gnt), .s_rdata_o(s_rdata),
      .v_req_i(v_req), .v_wr_i(v_wr), .v_base_addr_i(v_base), .v_wdata_i(v_wdata),
      .v_rdata_o(v_rdata), .v_done_o(v_done), .v_err_o(v_err), .stall_o(stall),
      .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_byte_en_o(mem_be), .mem_rdata_i(mem_rdata)
   );

   // Combinational-read memory, 1 KB window (address bits 9:2)
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (mem_req && mem_wr) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s_req = 1'b0; s_wr = 1'b0; s_addr = 32'd0; s_wdata = 32'd0; s_be = 2'b00;
      v_req = 1'b0; v_wr = 1'b0; v_base = 32'd0; v_wdata = '0;
   endtask

   // One vector instruction, checked cycle by cycle against the timing rules.
   task automatic do_vector(input logic wr, input logic [31:0] base, input logic [511:0] wdata,
                            input logic with_s);
      logic [31:0]  eb, a;
      logic [511:0] exp_rd;
      logic         err_path;
      eb       = {base[31:4], 4'h0};
      exp_rd   = rd_shadow;
      err_path = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      err_path = (base[3:0] != 4'h0);
`endif
      v_req = 1'b1; v_wr = wr; v_base = base; v_wdata = wdata;
      s_req = with_s; s_wr = 1'b0; s_addr = 32'h80; s_be = 2'b11;
      @(negedge clk);
      chk("accept_stall", stall, 1'b1);
      chk("accept_memreq", mem_req, 1'b0);
      chk("accept_gnt", s_gnt, 1'b0);
      chk("accept_err", v_err, err_path);
      chk("accept_done", v_done, 1'b0);
      next_cycle();
      if (!err_path) begin
         for (int i = 0; i < 16; i++) begin
            a = eb + 32'(4 * i);
            @(negedge clk);
            chk("acc_stall", stall, 1'b1);
            chk("acc_memreq", mem_req, 1'b1);
            chk("acc_memwr", mem_wr, wr);
            chk("acc_addr", mem_addr, a);
            chk("acc_be", mem_be, 2'b11);
            chk("acc_gnt", s_gnt, 1'b0);
            chk("acc_done", v_done, 1'b0);
            if (wr) begin
               chk("acc_wdata", mem_wdata, wdata[32*i +: 32]);
               ref_mem[a[9:2]] = wdata[32*i +: 32];
            end else begin
               exp_rd[32*i +: 32] = ref_mem[a[9:2]];
            end
            next_cycle();
         end
      end
      @(negedge clk);
      chk("done_pulse", v_done, 1'b1);
      chk("done_stall", stall, 1'b0);
      chk("done_memreq", mem_req, 1'b0);
      chk("done_gnt", s_gnt, 1'b0);
      chk("done_err", v_err, 1'b0);
      chk("done_rdata", v_rdata, exp_rd);
      rd_shadow = exp_rd;
      next_cycle();
      v_req = 1'b0;
      @(negedge clk);
      chk("idle_done", v_done, 1'b0);
      chk("idle_stall", stall, 1'b0);
      chk("idle_gnt", s_gnt, with_s);
      if (with_s) chk("idle_s_rdata", s_rdata, ref_mem[32'h80 >> 2]);
      next_cycle();
      s_req = 1'b0;
   endtask

   typedef struct {
      logic        s_req;
      logic        s_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  be;
      logic        exp_gnt;
      logic [31:0] exp_addr;
      logic        chk_rd;
      logic [31:0] exp_rdata;
   } svec_t;

   svec_t        svec [6];
   logic [511:0] wd;
   logic [31:0]  ra;
   logic         rw;

   initial begin
      svec[0] = '{1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 2'b11, 1'b1, 32'h40, 1'b0, 32'h0};
      svec[1] = '{1'b1, 1'b0, 32'h40, 32'h0,         2'b11, 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF};
      svec[2] = '{1'b1, 1'b1, 32'h44, 32'h1234_5678, 2'b10, 1'b1, 32'h44, 1'b0, 32'h0};
      svec[3] = '{1'b1, 1'b0, 32'h44, 32'h0,         2'b01, 1'b1, 32'h44, 1'b1, 32'h1234_5678};
      svec[4] = '{1'b0, 1'b0, 32'h48, 32'h0,         2'b11, 1'b0, 32'h0,  1'b0, 32'h0};
      svec[5] = '{1'b1, 1'b0, 32'h40, 32'h0,         2'b11, 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF};

      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
      rd_shadow = '0;
      idle_inputs();
      reset = 1'b1; mem_init = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0; mem_init = 1'b0;
      @(negedge clk);
      chk("rst_stall", stall, 1'b0);
      chk("rst_done", v_done, 1'b0);
      chk("rst_err", v_err, 1'b0);
      chk("rst_gnt", s_gnt, 1'b0);
      chk("rst_memreq", mem_req, 1'b0);
      chk("rst_memwr", mem_wr, 1'b0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_be", mem_be, 2'b00);
      chk("rst_vrdata", v_rdata, 512'd0);
      next_cycle();

      // Scalar pass-through table
      for (int i = 0; i < 6; i++) begin
         s_req = svec[i].s_req; s_wr = svec[i].s_wr; s_addr = svec[i].addr;
         s_wdata = svec[i].wdata; s_be = svec[i].be;
         @(negedge clk);
         chk("s_gnt", s_gnt, svec[i].exp_gnt);
         chk("s_stall", stall, 1'b0);
         chk("s_memreq", mem_req, svec[i].exp_gnt);
         chk("s_addr", mem_addr, svec[i].exp_addr);
         chk("s_memwr", mem_wr, svec[i].s_req & svec[i].s_wr);
         chk("s_be", mem_be, svec[i].s_req ? svec[i].be : 2'b00);
         if (svec[i].s_wr) chk("s_wdata", mem_wdata, svec[i].wdata);
         if (svec[i].chk_rd) chk("s_rdata", s_rdata, svec[i].exp_rdata);
         if (svec[i].s_req && svec[i].s_wr) ref_mem[svec[i].addr[9:2]] = svec[i].wdata;
         next_cycle();
      end
      idle_inputs();

      // Store 0x1000+k at 0x100, then load it back
      for (int k = 0; k < 16; k++) wd[32*k +: 32] = 32'h1000 + 32'(k);
      do_vector(1'b1, 32'h100, wd, 1'b0);
      do_vector(1'b0, 32'h100, '0, 1'b0);
      chk("row2", v_rdata[256 +: 128], 128'h0000100B_0000100A_00001009_00001008);

      // Scalar and vector collide: vector wins, scalar served after DONE
      for (int k = 0; k < 16; k++) wd[32*k +: 32] = $urandom;
      do_vector(1'b1, 32'h200, wd, 1'b1);

      // Misaligned base: trap or silent alignment depending on build
      do_vector(1'b0, 32'h104, '0, 1'b0);

      // Wrap past the top of the address space
      for (int k = 0; k < 16; k++) wd[32*k +: 32] = $urandom;
      do_vector(1'b1, 32'hFFFF_FFF0, wd, 1'b0);
      do_vector(1'b0, 32'hFFFF_FFF0, '0, 1'b0);

      // Reset pulsed at T+8 of a vector load
      v_req = 1'b1; v_wr = 1'b0; v_base = 32'h100;
      next_cycle();
      for (int i = 0; i < 7; i++) next_cycle();
      reset = 1'b1; v_req = 1'b0;
      next_cycle();
      reset = 1'b0;
      rd_shadow = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstmid_done", v_done, 1'b0);
         chk("rstmid_stall", stall, 1'b0);
         chk("rstmid_memreq", mem_req, 1'b0);
         chk("rstmid_vrdata", v_rdata, 512'd0);
         next_cycle();
      end

      // Randomized mix of scalar and vector traffic
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            rw = 1'($urandom_range(0, 1));
            ra = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            s_req = 1'b1; s_wr = rw; s_addr = ra; s_wdata = $urandom; s_be = 2'b11;
            @(negedge clk);
            chk("rnd_s_gnt", s_gnt, 1'b1);
            chk("rnd_s_addr", mem_addr, ra);
            if (!rw) chk("rnd_s_rdata", s_rdata, ref_mem[ra[9:2]]);
            else ref_mem[ra[9:2]] = s_wdata;
            next_cycle();
            idle_inputs();
         end else begin
            for (int k = 0; k < 16; k++) wd[32*k +: 32] = $urandom;
            do_vector(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h3C0)), wd,
                      1'($urandom_range(0, 1)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and arbiter for the single 32-bit data-memory port, shared between the scalar load/store path and the vector load/store path. A vector access (4 rows × 128 bits) is serialised into 16 word accesses while the core is stalled. Scalar accesses pass straight through whenever no vector transfer is in progress. Sits between control/execute/valu and the data memory.

## Interface
Parameters:
- VROWS, 4, vector rows per vector access
- ROW_WORDS, 4, 32-bit words per 128-bit row

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_req_i  in  1  scalar access request
- s_wr_i  in  1  scalar write (1) / read (0)
- s_addr_i  in  32  scalar byte address
- s_wdata_i  in  32  scalar write data
- s_byte_en_i  in  2  scalar access size (yarp_pkg encoding)
- s_gnt_o  out  1  scalar access granted this cycle
- s_rdata_o  out  32  scalar read data
- v_req_i  in  1  vector load/store request, level, held by the core until done
- v_wr_i  in  1  vector store (1) / load (0)
- v_base_addr_i  in  32  vector base byte address
- v_wdata_i  in  512  vector store data; row r at [128r+:128]
- v_rdata_o  out  512  vector load data, same packing
- v_done_o  out  1  one-cycle completion pulse
- v_err_o  out  1  misalignment error pulse (config-dependent)
- stall_o  out  1  hold PC/instruction
- mem_req_o, mem_wr_o  out  1  memory request / write
- mem_addr_o  out  32  memory byte address
- mem_wdata_o  out  32  memory write data
- mem_byte_en_o  out  2  memory access size
- mem_rdata_i  in  32  memory read data, combinational (same-cycle)

## Operation
- FSM states: IDLE, V_ACCESS, DONE. A 4-bit word counter k indexes the vector transfer.
- IDLE, v_req_i=0:
  - scalar pass-through: mem_* = s_*; s_gnt_o = s_req_i; s_rdata_o = mem_rdata_i.
- IDLE, v_req_i=1:
  - vector wins over any simultaneous scalar request; s_gnt_o=0.
  - latch base and v_wr_i; clear k to 0; go to V_ACCESS.
  - mem_req_o=0 in the accept cycle.
- V_ACCESS:
  - mem_req_o=1; mem_addr_o = base + 4k; mem_byte_en_o = word size (2'b11); mem_wr_o = latched wr.
  - Store: mem_wdata_o = word k = v_wdata_i[128(k/4) + 32(k%4) +: 32].
  - Load: capture mem_rdata_i into the same bit slice of v_rdata_o.
  - k increments each cycle. After k=15 go to DONE.
- DONE:
  - v_done_o=1 and stall_o=0, so the core writes back and advances.
  - v_req_i is ignored in this cycle (same instruction still present). Go to IDLE.
- stall_o = (IDLE & v_req_i) | V_ACCESS.
- s_gnt_o=0 and s_rdata_o=0 in V_ACCESS and DONE.
- v_rdata_o holds its value until the next vector load overwrites it.
- Base address arithmetic is 32-bit modulo; wrap past 0xFFFF_FFFC is permitted and not flagged.
- Reset values:
  - FSM=IDLE, k=0.
  - v_rdata_o=0.
  - v_done_o, v_err_o, stall_o, s_gnt_o, mem_req_o, mem_wr_o = 0.
  - mem_addr_o, mem_wdata_o, mem_byte_en_o = 0 when no scalar request is present.
- Reset asserted mid-transfer: next cycle is IDLE, k=0, no done pulse, partial v_rdata_o cleared. Memory writes already issued are not undone.

## Timing
- Accept cycle T: stall_o=1.
- Word accesses on T+1 … T+16.
- DONE on T+17: v_done_o=1, stall_o=0.
- Total vector latency: 18 cycles, identical for loads and stores.
- Back-to-back vector instructions: the next accept cycle is T+18 at the earliest (IDLE).
- Scalar latency: 0 extra cycles when idle.

## Configuration
- DMEM_ARB_ALIGN_CHECK_EN defined:
  - In IDLE, v_req_i=1 with v_base_addr_i[3:0] ≠ 0 raises v_err_o=1 for one cycle.
  - No memory access is issued. The FSM goes directly to DONE, so the instruction retires: v_done_o=1 on the next cycle and v_rdata_o is unchanged.
- Not defined:
  - v_base_addr_i[3:0] is forced to 0; v_err_o is tied to 0.

## Test plan
- Scalar write 0xDEADBEEF to 0x40, then read 0x40 while idle -> s_gnt_o=1 the same cycle; s_rdata_o=0xDEADBEEF; stall_o=0.
- Vector store with base 0x100, word k = 0x1000+k -> 16 mem writes on T+1..T+16 at 0x100..0x13C; v_done_o at T+17; stall_o high T..T+16.
- Vector load from 0x100 after that store -> v_rdata_o row 2 = {0x100B,0x100A,0x1009,0x1008} at T+17.
- s_req_i and v_req_i together in IDLE -> s_gnt_o=0 until DONE; the scalar request is serviced on the first IDLE cycle after DONE.
- reset pulsed at T+8 of a vector load -> IDLE at T+9; v_rdata_o=0; v_done_o never asserts.
- Base 0x104 with DMEM_ARB_ALIGN_CHECK_EN -> v_err_o=1 at T, no mem_req_o, v_done_o at T+1. Without the macro -> accesses start at 0x100.
